// File: rtl/seq_divider_if.sv
// seq_divider_if: request/result bundle for the sequential divider
interface seq_divider_if;
    logic       start;
    logic [0:5] dividend;
    logic [0:2] divisor;
    logic [0:5] quotient;
    logic [0:2] remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;
    modport master (output start, dividend, divisor,
                    input quotient, remainder, busy, done, div_by_zero);
    modport slave (input start, dividend, divisor,
                   output quotient, remainder, busy, done, div_by_zero);
endinterface

// File: rtl/seq_divider.sv
// seq_divider: 6-by-3 bit restoring divider, one quotient bit per clock
module seq_divider (
    input logic clk,
    input logic rst,
    seq_divider_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
    state_t state, state_nx;
    logic [5:0] dvd, a_sh, q_sh, q_nx, quot;
    logic [2:0] dsr, b, rem, cnt;
    logic [3:0] p, p_sh, p_nx;
    logic ge, dbz;
    // bus vectors are numbered with index 0 as the LSB, so reverse into [n:0] form
    assign dvd = {<<{bus.dividend}};
    assign dsr = {<<{bus.divisor}};
    assign p_sh = {p[2:0], a_sh[5]};
    assign ge = p_sh >= {1'b0, b};
    assign p_nx = ge ? p_sh - {1'b0, b} : p_sh;
    assign q_nx = {q_sh[4:0], ge};
    always_comb begin
        state_nx = IDLE;
        state_nx = (state == IDLE) ? (bus.start ? ((dsr == 3'd0) ? DONE : DIV) : IDLE) :
                   (state == DIV) ? ((cnt == 3'd5) ? DONE : DIV) : IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_sh <= '0;
            q_sh <= '0;
            quot <= '0;
            b <= '0;
            rem <= '0;
            cnt <= '0;
            p <= '0;
            dbz <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && bus.start) begin
                if (dsr == 3'd0) begin
                    quot <= 6'h3F;
                    rem <= '0;
                    dbz <= 1'b1;
                end else begin
                    a_sh <= dvd;
                    b <= dsr;
                    p <= '0;
                    q_sh <= '0;
                    cnt <= '0;
                end
            end else if (state == DIV) begin
                a_sh <= {a_sh[4:0], 1'b0};
                p <= p_nx;
                q_sh <= q_nx;
                cnt <= cnt + 3'd1;
                if (cnt == 3'd5) begin
                    quot <= q_nx;
                    rem <= p_nx[2:0];
                    dbz <= 1'b0;
                end
            end
        end
    end
    assign bus.quotient = {<<{quot}};
    assign bus.remainder = {<<{rem}};
    assign bus.busy = state == DIV;
    assign bus.done = state == DONE;
    assign bus.div_by_zero = dbz;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: random and directed divisions checked against a cycle-timed arithmetic model
module tb_seq_divider;
    logic clk = 1'b0;
    logic rst;
    int n_pass = 0;
    int n_total = 0;
    seq_divider_if bus();
    seq_divider dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;

    function automatic int r6(input logic [0:5] v);
        int x = 0;
        for (int i = 0; i < 6; i++) x = x | (int'(v[i]) << i);
        return x;
    endfunction
    function automatic int r3(input logic [0:2] v);
        int x = 0;
        for (int i = 0; i < 3; i++) x = x | (int'(v[i]) << i);
        return x;
    endfunction
    function automatic logic [0:5] w6(input int x);
        logic [0:5] v;
        for (int i = 0; i < 6; i++) v[i] = x[i];
        return v;
    endfunction
    function automatic logic [0:2] w3(input int x);
        logic [0:2] v;
        for (int i = 0; i < 3; i++) v[i] = x[i];
        return v;
    endfunction

    task automatic check(input string nm, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", nm, got, exp, $time);
    endtask

    // reference: result is a/b after a fixed 7-edge latency, or 63/0 flagged after 1 edge for b==0
    bit m_busy = 0, m_done = 0, m_z = 0;
    int m_q = 0, m_r = 0, m_steps = 0, p_q = 0, p_r = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 0; m_done <= 0; m_z <= 0; m_q <= 0; m_r <= 0; m_steps <= 0;
        end else if (m_done) begin
            m_done <= 0;
        end else if (m_busy) begin
            m_steps <= m_steps + 1;
            if (m_steps == 5) begin
                m_busy <= 0; m_done <= 1; m_q <= p_q; m_r <= p_r; m_z <= 0;
            end
        end else if (bus.start === 1'b1) begin
            if (r3(bus.divisor) == 0) begin
                m_q <= 63; m_r <= 0; m_z <= 1; m_done <= 1;
            end else begin
                p_q <= r6(bus.dividend) / r3(bus.divisor);
                p_r <= r6(bus.dividend) % r3(bus.divisor);
                m_steps <= 0; m_busy <= 1;
            end
        end
    end

    always @(negedge clk) begin
        check("quotient", r6(bus.quotient), m_q);
        check("remainder", r3(bus.remainder), m_r);
        check("div_by_zero", int'(bus.div_by_zero), int'(m_z));
        check("busy", int'(bus.busy), int'(m_busy));
        check("done", int'(bus.done), int'(m_done));
    end

    task automatic go(input int a, input int b);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.dividend = w6(a); bus.divisor = w3(b);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.dividend = w6(int'($urandom_range(63)));
        bus.divisor = w3(int'($urandom_range(7)));
    endtask

    task automatic wait_done(output int q, output int r, output int z, output int n, output int nb);
        n = 0; nb = 0;
        do begin
            @(negedge clk);
            n++;
            if (bus.busy) nb++;
        end while (!bus.done && n < 20);
        if (!bus.done) check("done_timeout", 0, 1);
        q = r6(bus.quotient); r = r3(bus.remainder); z = int'(bus.div_by_zero);
    endtask

    task automatic lit(input string nm, input int a, input int b, input int eq, input int er, input int ez);
        int q, r, z, n, nb;
        go(a, b);
        wait_done(q, r, z, n, nb);
        check({nm, "_q"}, q, eq);
        check({nm, "_r"}, r, er);
        check({nm, "_z"}, z, ez);
        check({nm, "_latency"}, n, (b == 0) ? 1 : 7);
        check({nm, "_busy_cycles"}, nb, (b == 0) ? 0 : 6);
    endtask

    initial begin
        int q, r, z, n, nb, a, b;
        rst = 1'b1; bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_q", r6(bus.quotient), 0);
        check("reset_busy", int'(bus.busy), 0);
        rst = 1'b0;
        lit("d45_6", 45, 6, 7, 3, 0);
        lit("d5_7", 5, 7, 0, 5, 0);
        lit("d63_1", 63, 1, 63, 0, 0);
        lit("d63_7", 63, 7, 9, 0, 0);
        lit("d20_0", 20, 0, 63, 0, 1);
        for (a = 0; a < 64; a++)
            for (b = 1; b < 8; b++) begin
                go(a, b);
                wait_done(q, r, z, n, nb);
                check("identity", q * b + r, a);
                check("rem_lt_div", int'(r < b), 1);
            end
        for (a = 0; a < 8; a++)
            for (b = 1; b < 8; b++) begin
                go(a * b, b);
                wait_done(q, r, z, n, nb);
                check("inverse_q", q, a);
                check("inverse_r", r, 0);
            end
        // start re-pulsed mid-division, then held across DONE into the first IDLE edge
        go(45, 6);
        repeat (2) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.dividend = w6(10); bus.divisor = w3(3);
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(q, r, z, n, nb);
        check("ignored_start_q", q, 7);
        check("ignored_start_r", r, 3);
        bus.start = 1'b1; bus.dividend = w6(50); bus.divisor = w3(7);
        repeat (2) @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(q, r, z, n, nb);
        check("b2b_q", q, 7);
        check("b2b_r", r, 1);
        check("b2b_latency", n, 7);
        // asynchronous reset in the middle of a division
        go(45, 6);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_rst_q", r6(bus.quotient), 0);
        check("async_rst_r", r3(bus.remainder), 0);
        check("async_rst_busy", int'(bus.busy), 0);
        check("async_rst_done", int'(bus.done), 0);
        bus.start = 1'b1; bus.dividend = w6(20); bus.divisor = w3(0);
        @(posedge clk); #1;
        bus.start = 1'b0; rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("start_in_rst_z", int'(bus.div_by_zero), 0);
        lit("after_rst", 45, 6, 7, 3, 0);
        repeat (80) begin
            a = int'($urandom_range(63));
            b = int'($urandom_range(7));
            go(a, b);
            wait_done(q, r, z, n, nb);
            if (b == 0) check("rand_dbz", z, 1);
            else check("rand_identity", q * b + r, a);
        end
        @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
